// File: rtl/bank_cmd_sched_pkg.sv
// Shared types for the single-request DRAM bank command scheduler.
package dram_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6
    } cmd_t;

    // 2'b00 is never produced by the table; it is decoded like MISS.
    typedef enum logic [1:0] {
        STAT_NONE     = 2'b00,
        STAT_HIT      = 2'b01,
        STAT_MISS     = 2'b10,
        STAT_CONFLICT = 2'b11
    } row_stat_t;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_LOOKUP       = 4'd1,
        S_WAIT_STAT    = 4'd2,
        S_PRE          = 4'd3,
        S_WAIT_RP      = 4'd4,
        S_ACT          = 4'd5,
        S_WAIT_RCD     = 4'd6,
        S_RW           = 4'd7,
        S_WAIT_DATA    = 4'd8,
        S_REF_PREA     = 4'd9,
        S_REF_WAIT_RP  = 4'd10,
        S_REF          = 4'd11,
        S_REF_WAIT_RFC = 4'd12
    } sched_state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } sched_req_t;

endpackage

// File: rtl/bank_cmd_sched_if.sv
// Request, policy-table and command-bus signals of the bank command scheduler.
interface bank_cmd_sched_if;
    import dram_sched_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_bank_group;
    logic [1:0]  req_bank;
    logic [15:0] req_row;
    logic [9:0]  req_col;
    logic        refresh_req;
    logic        refresh_ack;
    logic        pol_req_en;
    logic [1:0]  pol_bank_group;
    logic [1:0]  pol_bank;
    logic [15:0] pol_row;
    logic        pol_row_resolve;
    logic        pol_refresh;
    logic [1:0]  pol_row_stat;
    logic        cmd_valid;
    cmd_t        cmd;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        done;
    logic        done_write;

    // Environment side: front end, policy table and command bus consumer.
    modport master (
        output req_valid, req_write, req_bank_group, req_bank, req_row, req_col,
        output refresh_req, pol_row_stat,
        input  req_ready, refresh_ack, pol_req_en, pol_bank_group, pol_bank, pol_row,
        input  pol_row_resolve, pol_refresh, cmd_valid, cmd, cmd_bg, cmd_bank,
        input  cmd_row, cmd_col, done, done_write
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_write, req_bank_group, req_bank, req_row, req_col,
        input  refresh_req, pol_row_stat,
        output req_ready, refresh_ack, pol_req_en, pol_bank_group, pol_bank, pol_row,
        output pol_row_resolve, pol_refresh, cmd_valid, cmd, cmd_bg, cmd_bank,
        output cmd_row, cmd_col, done, done_write
    );

endinterface

// File: rtl/bank_cmd_sched_timing_counter.sv
// Shared timing down-counter: load wins, otherwise decrement and hold at zero.
module timing_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Counter register with load priority and saturation at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/bank_cmd_sched.sv
// Single-request DRAM command scheduler: classifies each access through the
// open-row policy table, sequences PRE/ACT/RD/WR and the PREA/REF refresh.
module bank_cmd_sched
    import dram_sched_pkg::*;
#(
    parameter int T_RP    = 4,
    parameter int T_RCD   = 4,
    parameter int T_CL    = 6,
    parameter int T_CWL   = 4,
    parameter int T_BURST = 4,
    parameter int T_RFC   = 32,
    parameter int CNT_W   = 8
) (
    input logic             CLK,
    input logic             nRST,
    bank_cmd_sched_if.slave bus
);

    // The counter is loaded on entry to a command state, so the command
    // cycle itself is the first cycle of the wait.
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(T_CL + T_BURST - 1);
    localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_CWL + T_BURST - 1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);

    sched_state_t     state_r, state_s;
    sched_req_t       req_r, req_s;
    logic             handshake_s, cnt_load_s, cnt_zero_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             ready_r, ready_s, done_r, done_s, done_write_r, done_write_s;
    logic             ack_r, ack_s, pol_en_r, pol_en_s, pol_ref_r, pol_ref_s;
    logic [1:0]       pol_bg_r, pol_bg_s, pol_bank_r, pol_bank_s;
    logic [15:0]      pol_row_r, pol_row_s;
    logic             cmd_valid_r, cmd_valid_s;
    cmd_t             cmd_r, cmd_s;
    logic [1:0]       cmd_bg_r, cmd_bg_s, cmd_bank_r, cmd_bank_s;
    logic [15:0]      cmd_row_r, cmd_row_s;
    logic [9:0]       cmd_col_r, cmd_col_s;

    // ready_r is low for the first IDLE cycle after done/refresh_ack and in reset.
    assign bus.req_ready = ready_r & ~bus.refresh_req;
    assign handshake_s   = bus.req_valid & bus.req_ready;

    // Next-state logic and request latch selection.
    always_comb begin
        state_s = state_r;
        req_s   = req_r;
        case (state_r)
            S_IDLE: begin
                if (bus.refresh_req) begin
                    state_s = S_REF_PREA;
                end else if (handshake_s) begin
                    state_s     = S_LOOKUP;
                    req_s.write = bus.req_write;
                    req_s.bg    = bus.req_bank_group;
                    req_s.bank  = bus.req_bank;
                    req_s.row   = bus.req_row;
                    req_s.col   = bus.req_col;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOOKUP:    state_s = S_WAIT_STAT;
            S_WAIT_STAT: begin
                case (bus.pol_row_stat)
                    STAT_HIT:      state_s = S_RW;
                    STAT_CONFLICT: state_s = S_PRE;
                    default:       state_s = S_ACT;
                endcase
            end
            S_PRE:          state_s = S_WAIT_RP;
            S_WAIT_RP:      state_s = cnt_zero_s ? S_LOOKUP : S_WAIT_RP;
            S_ACT:          state_s = S_WAIT_RCD;
            S_WAIT_RCD:     state_s = cnt_zero_s ? S_RW : S_WAIT_RCD;
            S_RW:           state_s = S_WAIT_DATA;
            S_WAIT_DATA:    state_s = cnt_zero_s ? S_IDLE : S_WAIT_DATA;
            S_REF_PREA:     state_s = S_REF_WAIT_RP;
            S_REF_WAIT_RP:  state_s = cnt_zero_s ? S_REF : S_REF_WAIT_RP;
            S_REF:          state_s = S_REF_WAIT_RFC;
            S_REF_WAIT_RFC: state_s = cnt_zero_s ? S_IDLE : S_REF_WAIT_RFC;
            default:        state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state, so every output is a register.
    always_comb begin
        cnt_load_s  = 1'b0;
        cnt_val_s   = {CNT_W{1'b0}};
        pol_en_s    = 1'b0;
        pol_bg_s    = 2'b00;
        pol_bank_s  = 2'b00;
        pol_row_s   = 16'h0000;
        pol_ref_s   = 1'b0;
        cmd_valid_s = 1'b0;
        cmd_s       = CMD_NOP;
        cmd_bg_s    = 2'b00;
        cmd_bank_s  = 2'b00;
        cmd_row_s   = 16'h0000;
        cmd_col_s   = 10'h000;
        case (state_s)
            S_LOOKUP: begin
                pol_en_s   = 1'b1;
                pol_bg_s   = req_s.bg;
                pol_bank_s = req_s.bank;
                pol_row_s  = req_s.row;
            end
            S_PRE: begin
                cnt_load_s  = 1'b1;
                cnt_val_s   = LD_RP;
                cmd_valid_s = 1'b1;
                cmd_s       = CMD_PRE;
                cmd_bg_s    = req_s.bg;
                cmd_bank_s  = req_s.bank;
            end
            S_ACT: begin
                cnt_load_s  = 1'b1;
                cnt_val_s   = LD_RCD;
                cmd_valid_s = 1'b1;
                cmd_s       = CMD_ACT;
                cmd_bg_s    = req_s.bg;
                cmd_bank_s  = req_s.bank;
                cmd_row_s   = req_s.row;
            end
            S_RW: begin
                cnt_load_s  = 1'b1;
                cnt_val_s   = req_s.write ? LD_WR : LD_RD;
                cmd_valid_s = 1'b1;
                cmd_s       = req_s.write ? CMD_WR : CMD_RD;
                cmd_bg_s    = req_s.bg;
                cmd_bank_s  = req_s.bank;
                cmd_col_s   = req_s.col;
            end
            S_REF_PREA: begin
                cnt_load_s  = 1'b1;
                cnt_val_s   = LD_RP;
                cmd_valid_s = 1'b1;
                cmd_s       = CMD_PREA;
            end
            S_REF: begin
                cnt_load_s  = 1'b1;
                cnt_val_s   = LD_RFC;
                cmd_valid_s = 1'b1;
                cmd_s       = CMD_REF;
                pol_ref_s   = 1'b1;
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
        done_s       = (state_r == S_WAIT_DATA) && cnt_zero_s;
        done_write_s = done_s && req_r.write;
        ack_s        = (state_r == S_REF_WAIT_RFC) && cnt_zero_s;
        ready_s      = (state_s == S_IDLE) && !done_s && !ack_s;
    end

    // State, request latch and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r      <= S_IDLE;
            req_r        <= '0;
            ready_r      <= 1'b0;
            done_r       <= 1'b0;
            done_write_r <= 1'b0;
            ack_r        <= 1'b0;
            pol_en_r     <= 1'b0;
            pol_bg_r     <= 2'b00;
            pol_bank_r   <= 2'b00;
            pol_row_r    <= 16'h0000;
            pol_ref_r    <= 1'b0;
            cmd_valid_r  <= 1'b0;
            cmd_r        <= CMD_NOP;
            cmd_bg_r     <= 2'b00;
            cmd_bank_r   <= 2'b00;
            cmd_row_r    <= 16'h0000;
            cmd_col_r    <= 10'h000;
        end else begin
            state_r      <= state_s;
            req_r        <= req_s;
            ready_r      <= ready_s;
            done_r       <= done_s;
            done_write_r <= done_write_s;
            ack_r        <= ack_s;
            pol_en_r     <= pol_en_s;
            pol_bg_r     <= pol_bg_s;
            pol_bank_r   <= pol_bank_s;
            pol_row_r    <= pol_row_s;
            pol_ref_r    <= pol_ref_s;
            cmd_valid_r  <= cmd_valid_s;
            cmd_r        <= cmd_s;
            cmd_bg_r     <= cmd_bg_s;
            cmd_bank_r   <= cmd_bank_s;
            cmd_row_r    <= cmd_row_s;
            cmd_col_r    <= cmd_col_s;
        end
    end

    timing_counter #(.CNT_W(CNT_W)) u_timing_counter (
        .clk      (CLK),
        .rst_n    (nRST),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .zero     (cnt_zero_s)
    );

    assign bus.done            = done_r;
    assign bus.done_write      = done_write_r;
    assign bus.refresh_ack     = ack_r;
    assign bus.pol_req_en      = pol_en_r;
    assign bus.pol_bank_group  = pol_bg_r;
    assign bus.pol_bank        = pol_bank_r;
    assign bus.pol_row         = pol_row_r;
    assign bus.pol_row_resolve = 1'b0;
    assign bus.pol_refresh     = pol_ref_r;
    assign bus.cmd_valid       = cmd_valid_r;
    assign bus.cmd             = cmd_r;
    assign bus.cmd_bg          = cmd_bg_r;
    assign bus.cmd_bank        = cmd_bank_r;
    assign bus.cmd_row         = cmd_row_r;
    assign bus.cmd_col         = cmd_col_r;

endmodule
